clic_param: RTL and testbench
=============================

Name: clic_param

Overview:
- Parametrised next-generation core-local interrupt controller with a configurable number of interrupt inputs and implemented control bits.
- Adds a level threshold register, per-input trigger polarity, a claim/acknowledge port that auto-clears edge-pending bits, a winner-level output and fully-decoded bus responses.
- Sits on the core's peripheral bus beside the timer; drives the core's external-interrupt request, id and level.

Parameters:
- NUM_IRPT, 32, number of interrupt inputs; legal range 2..4096.
- CTL_BITS, 8, implemented MSBs of each 8-bit clicintctl; legal range 1..8.
- ID_W, $clog2(NUM_IRPT), width of id fields; derived, not overridable.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clic_valid  in  1  bus access strobe; each high cycle is one access
- clic_addr  in  32  byte address, word aligned
- clic_wdata  in  32  write data
- clic_wstrb  in  4  byte strobes; all zero means read
- clic_rdata  out  32  read data, valid while clic_ready=1
- clic_ready  out  1  access complete
- clic_irpt  in  NUM_IRPT  raw interrupt lines, synchronous to clock
- clic_ack  in  1  core claims interrupt clic_ack_id (single-cycle pulse)
- clic_ack_id  in  ID_W  claimed id
- clic_meip  out  1  interrupt request
- clic_meid  out  ID_W  winning id
- clic_meil  out  8  winning level

Behaviour:
- Reset: every register, pending bit, pipeline stage and output is 0. This includes clic_ready, clic_rdata, clic_meip, clic_meid, clic_meil, nlbits and mintthresh.
- Reset is honoured mid-access: no ready is produced for an access in flight.
- Register map (byte addresses):
  - 0x0 cfg: nlbits[4:1] R/W; all other bits read 0.
  - 0x4 info (RO): num_interrupt[12:0]=NUM_IRPT, num_intctlbit[24:21]=CTL_BITS, all others 0.
  - 0x8 mintthresh[7:0] R/W.
  - 0x1000+4*i, for i < NUM_IRPT: ip[0], ie[8], trig[18:17], ctl[31:24]. Each byte is written only if its wstrb bit is set.
- Bus timing:
  - clic_ready=1 exactly one cycle after each valid cycle; rdata is registered with it.
  - Any unmapped address returns ready=1, rdata=0, and the write is ignored.
- ctl storage:
  - ctl8 = {ctl[7:8-CTL_BITS], ones}.
  - Writes to unimplemented low bits are ignored; those bits read 1.
- trig field: bit0 = edge mode (0 = level, 1 = edge); bit1 = polarity (0 = active-high/rising, 1 = active-low/falling).
- Pending-bit update, once per clock:
  - Level mode: ip <= irpt XOR trig[1]. Bus writes to ip are ignored.
  - Edge mode: a detected edge versus the previous-cycle sample sets ip. Otherwise, a bus write with wstrb[0] loads wdata[0]. Otherwise, clic_ack with a matching id clears ip.
  - Priority in edge mode: edge set > bus write > ack clear.
  - clic_ack with an id >= NUM_IRPT, or naming a level-mode input, has no effect.
- Level derivation, with n = min(nlbits, 8):
  - level8[j] = ctl8[j] for j >= 8-n, else 1.
  - n=0 gives level8 = 0xFF.
- Arbitration:
  - Candidates are inputs with ip & ie.
  - The largest ctl8 wins (this orders by level, then priority). Ties go to the lowest id.
- Pipeline:
  - Stage 1 registers per-input {ip&ie, ctl8}.
  - A combinational reduction tree feeds output registers.
  - Output registers: clic_meip = (any candidate) && (winner level8 > mintthresh). clic_meid and clic_meil are the winner's id and level8 when meip=1, else 0.
- Latency:
  - A line change sampled at edge E0 sets ip at E0; outputs update at E2.
  - A bus write to ie, ctl, trig, nlbits or mintthresh taking effect at E0 is reflected at E2.
  - An ack at E0 clears ip at E0's edge; meip drops at E2 unless another candidate qualifies.
- Id 0 is an ordinary interrupt.

Decomposition:
- wires package: clic_attr typedef {trig[1:0]} and the arbiter key struct {valid, ctl8, id}.
- constants package: register offsets 0x0, 0x4, 0x8, 0x1000.
- One sub-module, clic_max_tree: combinational, parametrised on NUM_IRPT. It takes the key array and returns the winner key, applying the largest-ctl8 / lowest-id rule.

Test Plan:
1. Reset asserted mid-read of 0x4 -> no ready; meip=0, meid=0, meil=0, rdata=0 after release.
2. nlbits=8, thresh=0, id 5: ie=1, ctl=0xC0, trig=00; drive irpt[5]=1 before E0 -> meip=1, meid=5, meil=0xC0 at E2. Deassert -> meip=0 two cycles later.
3. Ids 3 and 7 both with ctl=0x80 -> meid=3. Write id 7 ctl=0x90 -> meid=7 two cycles after the write.
4. Id 2 with trig=01: one-cycle pulse -> ip latched 1. ack id 2 -> ip=0, meip=0 two cycles later. Ack in the same cycle as a new edge -> ip stays 1. trig=11: falling edge sets ip.
5. Level 0x80 with mintthresh=0x80 -> meip=0. Write mintthresh=0x7F -> meip=1, meil=0x80.
6. Read 0x4 -> 0x01000020. Read 0x200 -> ready=1, rdata=0. In a CTL_BITS=4 instance, write ctl=0xA5 -> reads back 0xAF.

Source files
------------

// File: rtl/clic_param_pkg.sv
// clic_param_pkg: shared types, register offsets and arbitration helper for the CLIC
package clic_param_pkg;
  localparam int MAX_ID_W = 12;
  localparam logic [31:0] OFF_CFG    = 32'h0000_0000;
  localparam logic [31:0] OFF_INFO   = 32'h0000_0004;
  localparam logic [31:0] OFF_THRESH = 32'h0000_0008;
  localparam logic [31:0] OFF_INT    = 32'h0000_1000;
  typedef struct packed {
    logic [1:0] trig;
  } clic_attr_t;
  typedef struct packed {
    logic                valid;
    logic [7:0]          ctl8;
    logic [MAX_ID_W-1:0] id;
  } clic_key_t;
  function automatic clic_key_t key_max(clic_key_t a, clic_key_t b);
    return (b.valid && (!a.valid || b.ctl8 > a.ctl8)) ? b : a;
  endfunction
endpackage

// File: rtl/clic_max_tree.sv
// clic_max_tree: combinational tournament picking the largest ctl8, lowest id on ties
module clic_max_tree import clic_param_pkg::*; #(
  parameter int NUM_IRPT = 32
) (
  input  clic_key_t keys [NUM_IRPT],
  output clic_key_t win
);
  localparam int LVL = $clog2(NUM_IRPT);
  localparam int P = 1 << LVL;
  clic_key_t node [P];
  // Pairwise reduction; the left (lower id) side is kept on equal ctl8
  always_comb begin
    node = '{default: '0};
    for (int k = 0; k < NUM_IRPT; k++) node[k] = keys[k];
    for (int l = LVL; l > 0; l--)
      for (int k = 0; k < (1 << (l - 1)); k++) node[k] = key_max(node[2 * k], node[2 * k + 1]);
    win = node[0];
  end
endmodule

// File: rtl/clic_param.sv
// clic_param: parametrised core-local interrupt controller with threshold, polarity and claim port
module clic_param import clic_param_pkg::*; #(
  parameter int NUM_IRPT = 32,
  parameter int CTL_BITS = 8,
  localparam int ID_W = $clog2(NUM_IRPT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clic_valid,
  input  logic [31:0]         clic_addr,
  input  logic [31:0]         clic_wdata,
  input  logic [3:0]          clic_wstrb,
  output logic [31:0]         clic_rdata,
  output logic                clic_ready,
  input  logic [NUM_IRPT-1:0] clic_irpt,
  input  logic                clic_ack,
  input  logic [ID_W-1:0]     clic_ack_id,
  output logic                clic_meip,
  output logic [ID_W-1:0]     clic_meid,
  output logic [7:0]          clic_meil
);
  localparam logic [7:0] CTL_ONES = 8'hFF >> CTL_BITS;
  logic [3:0] nlbits, nl_s1;
  logic [7:0] mintthresh, thr_s1, lvl;
  logic [NUM_IRPT-1:0] ip, ie, irpt_q, cand_s1, edge_hit, ip_wr, ack_hit;
  clic_attr_t attr [NUM_IRPT];
  logic [7:0] ctl [NUM_IRPT];
  logic [7:0] ctl_s1 [NUM_IRPT];
  logic wr, int_hit, hit;
  logic [31:0] off, rd;
  logic [ID_W-1:0] idx;
  clic_key_t keys [NUM_IRPT];
  clic_key_t win;
  // Address decode and read-data mux for the current access
  always_comb begin
    wr = clic_valid && |clic_wstrb;
    off = clic_addr - OFF_INT;
    int_hit = clic_addr >= OFF_INT && off[31:2] < 30'(NUM_IRPT) && clic_addr[1:0] == 2'b00;
    idx = off[ID_W+1:2];
    rd = clic_addr == OFF_CFG ? {27'b0, nlbits, 1'b0}
       : clic_addr == OFF_INFO ? {7'b0, 4'(CTL_BITS), 8'b0, 13'(NUM_IRPT)}
       : clic_addr == OFF_THRESH ? {24'b0, mintthresh}
       : int_hit ? {ctl[idx] | CTL_ONES, 5'b0, attr[idx].trig, 8'b0, ie[idx], 7'b0, ip[idx]}
       : 32'b0;
  end
  // Per-input edge detection, bus writes to ip and claim matching
  always_comb
    for (int i = 0; i < NUM_IRPT; i++) begin
      edge_hit[i] = attr[i].trig[1] ? irpt_q[i] & ~clic_irpt[i] : clic_irpt[i] & ~irpt_q[i];
      ip_wr[i] = wr && int_hit && clic_wstrb[0] && idx == ID_W'(i);
      ack_hit[i] = clic_ack && clic_ack_id == ID_W'(i);
    end
  // Bus-writable configuration and per-input attributes, byte-strobed
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      nlbits <= '0;
      mintthresh <= '0;
      ie <= '0;
      attr <= '{default: '0};
      ctl <= '{default: '0};
    end else if (wr) begin
      if (clic_addr == OFF_CFG && clic_wstrb[0]) nlbits <= clic_wdata[4:1];
      if (clic_addr == OFF_THRESH && clic_wstrb[0]) mintthresh <= clic_wdata[7:0];
      if (int_hit && clic_wstrb[1]) ie[idx] <= clic_wdata[8];
      if (int_hit && clic_wstrb[2]) attr[idx].trig <= clic_wdata[18:17];
      if (int_hit && clic_wstrb[3]) ctl[idx] <= clic_wdata[31:24];
    end
  // Pending bits: level inputs track the line, edge inputs latch with set > write > claim
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ip <= '0;
      irpt_q <= '0;
    end else begin
      irpt_q <= clic_irpt;
      for (int i = 0; i < NUM_IRPT; i++)
        ip[i] <= !attr[i].trig[0] ? clic_irpt[i] ^ attr[i].trig[1]
               : edge_hit[i] ? 1'b1
               : ip_wr[i] ? clic_wdata[0]
               : ack_hit[i] ? 1'b0 : ip[i];
    end
  // Stage 1: candidate flags, effective ctl8 and the level/threshold settings that go with them
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cand_s1 <= '0;
      ctl_s1 <= '{default: '0};
      nl_s1 <= '0;
      thr_s1 <= '0;
    end else begin
      cand_s1 <= ip & ie;
      for (int i = 0; i < NUM_IRPT; i++) ctl_s1[i] <= ctl[i] | CTL_ONES;
      nl_s1 <= nlbits;
      thr_s1 <= mintthresh;
    end
  // Arbiter keys carry their own id so the tree needs no position bookkeeping
  always_comb
    for (int i = 0; i < NUM_IRPT; i++) keys[i] = '{valid: cand_s1[i], ctl8: ctl_s1[i], id: MAX_ID_W'(i)};
  clic_max_tree #(.NUM_IRPT(NUM_IRPT)) u_tree (.keys(keys), .win(win));
  // Winner level: bits below the top nlbits are forced to one
  always_comb begin
    lvl = win.ctl8 | (8'hFF >> (nl_s1 > 4'd8 ? 4'd8 : nl_s1));
    hit = win.valid && lvl > thr_s1;
  end
  // Output request registers and the single-cycle bus response
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      clic_meip <= 1'b0;
      clic_meid <= '0;
      clic_meil <= '0;
      clic_ready <= 1'b0;
      clic_rdata <= '0;
    end else begin
      clic_meip <= hit;
      clic_meid <= hit ? win.id[ID_W-1:0] : '0;
      clic_meil <= hit ? lvl : '0;
      clic_ready <= clic_valid;
      clic_rdata <= clic_valid ? rd : '0;
    end
endmodule

// File: tb/tb_clic_param.sv
// tb_clic_param: directed checks of the CLIC bus, pending, arbitration and threshold behaviour
module tb_clic_param;
  logic clock = 0, reset = 1, valid = 0, valid2 = 0, ack = 0;
  logic [31:0] addr = 0, wdata = 0, irpt = 0;
  logic [3:0] wstrb = 0;
  logic [4:0] ack_id = 0;
  logic [31:0] rdata, rdata2;
  logic ready, ready2, meip, meip2;
  logic [4:0] meid, meid2;
  logic [7:0] meil, meil2;
  int tests = 0, fails = 0;

  clic_param dut (.clock(clock), .reset(reset), .clic_valid(valid), .clic_addr(addr), .clic_wdata(wdata),
    .clic_wstrb(wstrb), .clic_rdata(rdata), .clic_ready(ready), .clic_irpt(irpt), .clic_ack(ack),
    .clic_ack_id(ack_id), .clic_meip(meip), .clic_meid(meid), .clic_meil(meil));
  clic_param #(.CTL_BITS(4)) dut4 (.clock(clock), .reset(reset), .clic_valid(valid2), .clic_addr(addr),
    .clic_wdata(wdata), .clic_wstrb(wstrb), .clic_rdata(rdata2), .clic_ready(ready2), .clic_irpt(irpt),
    .clic_ack(ack), .clic_ack_id(ack_id), .clic_meip(meip2), .clic_meid(meid2), .clic_meil(meil2));

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus(input bit d2, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output logic rdy);
    @(negedge clock);
    addr = a; wdata = d; wstrb = s;
    if (d2) valid2 = 1; else valid = 1;
    @(negedge clock);
    valid = 0; valid2 = 0; wstrb = 0;
    r = d2 ? rdata2 : rdata;
    rdy = d2 ? ready2 : ready;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic k;
    bus(0, a, d, s, r, k);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic k;
    cyc(2);
    reset = 0;
    cyc(1);
    addr = 32'h4; valid = 1;
    #2 reset = 1;
    @(negedge clock);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_flight got %0h exp 0", ready); end
    reset = 0; valid = 0;
    cyc(1);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready_after got %0h exp 0", ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %0h exp 0", rdata); end
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL reset_meip got %0h exp 0", meip); end
    tests++; if (meid !== 5'h0) begin fails++; $display("FAIL reset_meid got %0h exp 0", meid); end
    tests++; if (meil !== 8'h0) begin fails++; $display("FAIL reset_meil got %0h exp 0", meil); end
    bus(0, 32'h0, 0, 4'h0, r, k);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_cfg got %0h exp 0", r); end
    bus(0, 32'h8, 0, 4'h0, r, k);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_thresh got %0h exp 0", r); end
  endtask

  task automatic test_level;
    wr(32'h0, 32'h10, 4'hF);
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h1014, 32'hC000_0100, 4'hF);
    irpt[5] = 1;
    cyc(2);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL level_early got %0h exp 0", meip); end
    cyc(1);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL level_meip got %0h exp 1", meip); end
    tests++; if (meid !== 5'd5) begin fails++; $display("FAIL level_meid got %0h exp 5", meid); end
    tests++; if (meil !== 8'hC0) begin fails++; $display("FAIL level_meil got %0h exp c0", meil); end
    irpt[5] = 0;
    cyc(2);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL level_hold got %0h exp 1", meip); end
    cyc(1);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL level_drop got %0h exp 0", meip); end
    tests++; if (meil !== 8'h0) begin fails++; $display("FAIL level_drop_meil got %0h exp 0", meil); end
  endtask

  task automatic test_tie;
    wr(32'h100C, 32'h8000_0100, 4'hF);
    wr(32'h101C, 32'h8000_0100, 4'hF);
    irpt[3] = 1; irpt[7] = 1;
    cyc(3);
    tests++; if (meid !== 5'd3) begin fails++; $display("FAIL tie_meid got %0h exp 3", meid); end
    tests++; if (meil !== 8'h80) begin fails++; $display("FAIL tie_meil got %0h exp 80", meil); end
    wr(32'h101C, 32'h9000_0000, 4'b1000);
    cyc(1);
    tests++; if (meid !== 5'd3) begin fails++; $display("FAIL tie_early got %0h exp 3", meid); end
    cyc(1);
    tests++; if (meid !== 5'd7) begin fails++; $display("FAIL tie_raise_meid got %0h exp 7", meid); end
    tests++; if (meil !== 8'h90) begin fails++; $display("FAIL tie_raise_meil got %0h exp 90", meil); end
    irpt[3] = 0; irpt[7] = 0;
    cyc(3);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL tie_clear got %0h exp 0", meip); end
  endtask

  task automatic test_edge;
    logic [31:0] r;
    logic k;
    wr(32'h1008, 32'hA002_0100, 4'hF);
    irpt[2] = 1;
    cyc(1);
    irpt[2] = 0;
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA002_0101) begin fails++; $display("FAIL edge_latch got %0h exp a0020101", r); end
    tests++; if (k !== 1'b1) begin fails++; $display("FAIL edge_ready got %0h exp 1", k); end
    tests++; if (meid !== 5'd2 || meil !== 8'hA0) begin fails++; $display("FAIL edge_win got %0h/%0h exp 2/a0", meid, meil); end
    ack = 1; ack_id = 5'd2;
    cyc(1);
    ack = 0;
    cyc(1);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL ack_early got %0h exp 1", meip); end
    cyc(1);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ack_clear got %0h exp 0", meip); end
    irpt[2] = 1; ack = 1; ack_id = 5'd2;
    cyc(1);
    irpt[2] = 0; ack = 0;
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA002_0101) begin fails++; $display("FAIL edge_beats_ack got %0h exp a0020101", r); end
    ack = 1;
    cyc(1);
    ack = 0;
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA002_0100) begin fails++; $display("FAIL ack_only got %0h exp a0020100", r); end
    wr(32'h1008, 32'h0006_0000, 4'b0100);
    irpt[2] = 1;
    cyc(1);
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA006_0100) begin fails++; $display("FAIL fall_rise_ignored got %0h exp a0060100", r); end
    irpt[2] = 0;
    cyc(1);
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA006_0101) begin fails++; $display("FAIL fall_set got %0h exp a0060101", r); end
    wr(32'h1008, 32'h0, 4'b0011);
    bus(0, 32'h1008, 0, 4'h0, r, k);
    tests++; if (r !== 32'hA006_0000) begin fails++; $display("FAIL edge_bus_clear got %0h exp a0060000", r); end
  endtask

  task automatic test_thresh;
    wr(32'h8, 32'h80, 4'hF);
    wr(32'h1024, 32'h8000_0100, 4'hF);
    irpt[9] = 1;
    cyc(3);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL thresh_equal got %0h exp 0", meip); end
    wr(32'h8, 32'h7F, 4'h1);
    cyc(1);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL thresh_early got %0h exp 0", meip); end
    cyc(1);
    tests++; if (meip !== 1'b1 || meid !== 5'd9) begin fails++; $display("FAIL thresh_pass got %0h/%0h exp 1/9", meip, meid); end
    tests++; if (meil !== 8'h80) begin fails++; $display("FAIL thresh_meil got %0h exp 80", meil); end
    wr(32'h0, 32'h8, 4'h1);
    cyc(2);
    tests++; if (meil !== 8'h8F) begin fails++; $display("FAIL nlbits4_meil got %0h exp 8f", meil); end
    wr(32'h0, 32'h0, 4'h1);
    cyc(2);
    tests++; if (meil !== 8'hFF) begin fails++; $display("FAIL nlbits0_meil got %0h exp ff", meil); end
    irpt[9] = 0;
    cyc(3);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL thresh_clear got %0h exp 0", meip); end
  endtask

  task automatic test_regs;
    logic [31:0] r;
    logic k;
    bus(0, 32'h4, 0, 4'h0, r, k);
    tests++; if (r !== 32'h0100_0020) begin fails++; $display("FAIL info got %0h exp 01000020", r); end
    wr(32'h200, 32'hFFFF_FFFF, 4'hF);
    bus(0, 32'h200, 0, 4'h0, r, k);
    tests++; if (k !== 1'b1 || r !== 32'h0) begin fails++; $display("FAIL unmapped got %0h/%0h exp 1/0", k, r); end
    bus(0, 32'h1080, 0, 4'h0, r, k);
    tests++; if (k !== 1'b1 || r !== 32'h0) begin fails++; $display("FAIL past_last got %0h/%0h exp 1/0", k, r); end
    wr(32'h0, 32'hFFFF_FFFF, 4'hF);
    bus(0, 32'h0, 0, 4'h0, r, k);
    tests++; if (r !== 32'h1E) begin fails++; $display("FAIL cfg_mask got %0h exp 1e", r); end
    bus(1, 32'h1000, 32'hA500_0000, 4'b1000, r, k);
    bus(1, 32'h1000, 0, 4'h0, r, k);
    tests++; if (r !== 32'hAF00_0000) begin fails++; $display("FAIL ctl4_readback got %0h exp af000000", r); end
    bus(1, 32'h4, 0, 4'h0, r, k);
    tests++; if (r !== 32'h0080_0020) begin fails++; $display("FAIL ctl4_info got %0h exp 00800020", r); end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    addr = 32'h4; valid = 1;
    @(negedge clock);
    tests++; if (ready !== 1'b1 || rdata !== 32'h0100_0020) begin fails++; $display("FAIL b2b_first got %0h/%0h exp 1/01000020", ready, rdata); end
    addr = 32'h8;
    @(negedge clock);
    tests++; if (ready !== 1'b1 || rdata !== 32'h7F) begin fails++; $display("FAIL b2b_second got %0h/%0h exp 1/7f", ready, rdata); end
    valid = 0;
    @(negedge clock);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_idle got %0h exp 0", ready); end
  endtask

  initial begin
    test_reset;
    test_level;
    test_tie;
    test_edge;
    test_thresh;
    test_back_to_back;
    test_regs;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
